// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default constants for the multi-port register file
package regfile_pkg;

  // Clear engine states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  // Default geometry of the datapath register file
  localparam int REGFILE_W        = 8;
  localparam int REGFILE_D        = 4;
  localparam int REGFILE_NR       = 2;
  localparam int REGFILE_ZERO_REG = 15;
  localparam int REGFILE_TAP0     = 13;
  localparam int REGFILE_TAP1     = 14;

  // Number of registers held for a given address width
  function automatic int num_regs(input int d);
    return 1 << d;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - sequential clear engine walking every register index once
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int D = REGFILE_D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_req_i,
  output logic         clr_we_o,
  output logic [D-1:0] clr_addr_o,
  output logic         busy_o,
  output logic         clear_done_o
);

  clr_state_t   state_q, state_d;
  logic [D-1:0] idx_q, idx_d;

  // State and index registers; reset aborts any clear in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: one register zeroed per CLEAR cycle, then a single DONE cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clear_req_i) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == '1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state only
  always_comb begin
    clr_we_o     = (state_q == CLEAR);
    clr_addr_o   = idx_q;
    busy_o       = (state_q != IDLE);
    clear_done_o = (state_q == DONE);
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with bypass, zero register, dirty map and clear engine
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int W        = REGFILE_W,
  parameter int D        = REGFILE_D,
  parameter int NR       = REGFILE_NR,
  parameter int ZERO_REG = REGFILE_ZERO_REG,
  parameter int BYPASS   = 1,
  parameter int TAP0     = REGFILE_TAP0,
  parameter int TAP1     = REGFILE_TAP1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [D-1:0]      waddr,
  input  logic [W-1:0]      data_in,
  input  logic [NR*D-1:0]   raddr,
  output logic [NR*W-1:0]   data_out,
  output logic [W-1:0]      tap0,
  output logic [W-1:0]      tap1,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done,
  output logic [2**D-1:0]   dirty
);

  localparam int           NREG   = num_regs(D);
  localparam logic [D-1:0] ZADDR  = D'(ZERO_REG);
  localparam logic [D-1:0] T0ADDR = D'(TAP0);
  localparam logic [D-1:0] T1ADDR = D'(TAP1);
  localparam bit           BYP_ON = (BYPASS != 0);

  logic [W-1:0]    regs_q [NREG];
  logic [W-1:0]    regs_d [NREG];
  logic [NREG-1:0] dirty_q, dirty_d;

  logic            clr_we;
  logic [D-1:0]    clr_addr;
  logic            wr_acc;

  regfile_clear_fsm #(
    .D (D)
  ) u_clear_fsm (
    .clk          (clk),
    .rst          (reset),
    .clear_req_i  (clear_req),
    .clr_we_o     (clr_we),
    .clr_addr_o   (clr_addr),
    .busy_o       (busy),
    .clear_done_o (clear_done)
  );

  // A write lands only while the clear engine is idle and never on the zero register
  assign wr_acc = write_en && !busy && (waddr != ZADDR);

  // Next storage contents: the clear engine and the write port never act in the same cycle
  always_comb begin
    regs_d  = regs_q;
    dirty_d = dirty_q;
    if (clr_we) begin
      if (clr_addr != ZADDR) begin
        regs_d[clr_addr] = '0;
      end
      dirty_d[clr_addr] = 1'b0;
    end else if (wr_acc) begin
      regs_d[waddr]  = data_in;
      dirty_d[waddr] = 1'b1;
    end
  end

  // Storage and dirty bitmap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      dirty_q <= '0;
    end else begin
      regs_q  <= regs_d;
      dirty_q <= dirty_d;
    end
  end

  assign dirty = dirty_q;

  // One combinational read path per port, each with its own bypass comparator
  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [D-1:0] ra;
    logic         hit;
    assign ra  = raddr[k*D +: D];
    assign hit = BYP_ON && wr_acc && (waddr == ra);
    assign data_out[k*W +: W] = (ra == ZADDR) ? '0 :
                                hit           ? data_in : regs_q[ra];
  end

  // Fixed taps obey the same zero and bypass rules as the read ports
  logic t0_hit, t1_hit;
  assign t0_hit = BYP_ON && wr_acc && (waddr == T0ADDR);
  assign t1_hit = BYP_ON && wr_acc && (waddr == T1ADDR);
  assign tap0   = (T0ADDR == ZADDR) ? '0 : t0_hit ? data_in : regs_q[T0ADDR];
  assign tap1   = (T1ADDR == ZADDR) ? '0 : t1_hit ? data_in : regs_q[T1ADDR];

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp with and without bypass
module tb_regfile_mp;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int NR   = 2;
  localparam int NREG = 16;
  localparam logic [D-1:0] ZA = 4'd15;

  logic            clk = 1'b0;
  logic            reset;
  logic            write_en;
  logic [D-1:0]    waddr;
  logic [W-1:0]    data_in;
  logic [NR*D-1:0] raddr;
  logic            clear_req;

  logic [NR*W-1:0] dout_b, dout_n;
  logic [W-1:0]    t0_b, t1_b, t0_n, t1_n;
  logic            busy_b, busy_n, done_b, done_n;
  logic [NREG-1:0] dirty_b, dirty_n;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]    mreg [NREG];
  logic [W-1:0]    snap [NREG];
  logic [NREG-1:0] mdirty;

  always #5 clk = ~clk;

  regfile_mp #(.W(W), .D(D), .NR(NR), .ZERO_REG(15), .BYPASS(1), .TAP0(13), .TAP1(14)) dut_b (
    .clk(clk), .reset(reset), .write_en(write_en), .waddr(waddr), .data_in(data_in),
    .raddr(raddr), .data_out(dout_b), .tap0(t0_b), .tap1(t1_b), .clear_req(clear_req),
    .busy(busy_b), .clear_done(done_b), .dirty(dirty_b));

  regfile_mp #(.W(W), .D(D), .NR(NR), .ZERO_REG(15), .BYPASS(0), .TAP0(13), .TAP1(14)) dut_n (
    .clk(clk), .reset(reset), .write_en(write_en), .waddr(waddr), .data_in(data_in),
    .raddr(raddr), .data_out(dout_n), .tap0(t0_n), .tap1(t1_n), .clear_req(clear_req),
    .busy(busy_n), .clear_done(done_n), .dirty(dirty_n));

  // Expected idle-time read of address a for a file with or without forwarding
  function automatic logic [W-1:0] exp_rd(input logic [D-1:0] a, input bit byp);
    if (a == ZA) return '0;
    if (byp && write_en && waddr == a) return data_in;
    return mreg[a];
  endfunction

  // Model update at a clock edge while the clear engine is idle
  task automatic commit();
    if (write_en && waddr != ZA) begin
      mreg[waddr]   = data_in;
      mdirty[waddr] = 1'b1;
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < NREG; i++) mreg[i] = '0;
    mdirty = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; write_en = 1'b0; clear_req = 1'b0;
    waddr = '0; data_in = '0; raddr = '0;
    model_zero();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) begin
      n_checks++;
      if (dout_b[k*W +: W] !== 8'h00) begin
        n_fail++; $display("FAIL reset_dout_b port %0d: got %h want 00", k, dout_b[k*W +: W]);
      end
      n_checks++;
      if (dout_n[k*W +: W] !== 8'h00) begin
        n_fail++; $display("FAIL reset_dout_n port %0d: got %h want 00", k, dout_n[k*W +: W]);
      end
    end
    n_checks++;
    if ({t0_b, t1_b} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_taps: got %h %h want 00 00", t0_b, t1_b);
    end
    n_checks++;
    if ({busy_b, done_b, busy_n, done_n} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_busy_done: got %b want 0000", {busy_b, done_b, busy_n, done_n});
    end
    n_checks++;
    if (dirty_b !== 16'h0000) begin
      n_fail++; $display("FAIL reset_dirty: got %h want 0000", dirty_b);
    end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    write_en = 1'b1; waddr = 4'd3; data_in = 8'hA5; raddr = {4'd0, 4'd3};
    @(posedge clk); commit(); #1;
    write_en = 1'b0;
    #1;
    n_checks++;
    if (dout_b[0 +: W] !== 8'hA5) begin
      n_fail++; $display("FAIL write_read_b: got %h want a5", dout_b[0 +: W]);
    end
    n_checks++;
    if (dout_n[0 +: W] !== 8'hA5) begin
      n_fail++; $display("FAIL write_read_n: got %h want a5", dout_n[0 +: W]);
    end
    n_checks++;
    if (dirty_b !== 16'h0008) begin
      n_fail++; $display("FAIL write_dirty: got %h want 0008", dirty_b);
    end
  endtask

  task automatic test_bypass();
    write_en = 1'b1; waddr = 4'd7; data_in = 8'h5A; raddr = {4'd7, 4'd3};
    #1;
    n_checks++;
    if (dout_b[W +: W] !== 8'h5A) begin
      n_fail++; $display("FAIL bypass_on: got %h want 5a", dout_b[W +: W]);
    end
    n_checks++;
    if (dout_n[W +: W] !== 8'h00) begin
      n_fail++; $display("FAIL bypass_off: got %h want 00", dout_n[W +: W]);
    end
    n_checks++;
    if (dout_b[0 +: W] !== 8'hA5) begin
      n_fail++; $display("FAIL bypass_other_port: got %h want a5", dout_b[0 +: W]);
    end
    @(posedge clk); commit(); #1;
    write_en = 1'b0;
    #1;
    n_checks++;
    if ({dout_b[W +: W], dout_n[W +: W]} !== 16'h5A5A) begin
      n_fail++; $display("FAIL bypass_after: got %h %h want 5a 5a", dout_b[W +: W], dout_n[W +: W]);
    end
  endtask

  task automatic test_zero_reg();
    write_en = 1'b1; waddr = ZA; data_in = 8'hFF; raddr = {ZA, ZA};
    #1;
    n_checks++;
    if ({dout_b, dout_n} !== 32'h0) begin
      n_fail++; $display("FAIL zero_same_cycle: got %h %h want 0000 0000", dout_b, dout_n);
    end
    @(posedge clk); commit(); #1;
    write_en = 1'b0;
    #1;
    n_checks++;
    if ({dout_b, dout_n} !== 32'h0) begin
      n_fail++; $display("FAIL zero_after: got %h %h want 0000 0000", dout_b, dout_n);
    end
    n_checks++;
    if (dirty_b[15] !== 1'b0 || dirty_n[15] !== 1'b0) begin
      n_fail++; $display("FAIL zero_dirty: got %b %b want 0 0", dirty_b[15], dirty_n[15]);
    end
  endtask

  task automatic test_taps();
    write_en = 1'b1; waddr = 4'd13; data_in = 8'h11;
    #1;
    n_checks++;
    if (t0_b !== 8'h11 || t0_n !== 8'h00) begin
      n_fail++; $display("FAIL tap0_bypass: got %h %h want 11 00", t0_b, t0_n);
    end
    @(posedge clk); commit(); #1;
    waddr = 4'd14; data_in = 8'h22;
    @(posedge clk); commit(); #1;
    write_en = 1'b0;
    #1;
    n_checks++;
    if ({t0_b, t1_b, t0_n, t1_n} !== 32'h11221122) begin
      n_fail++; $display("FAIL taps: got %h %h %h %h want 11 22 11 22", t0_b, t1_b, t0_n, t1_n);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 300; it++) begin
      write_en = 1'($urandom_range(0, 1));
      waddr    = 4'($urandom);
      data_in  = 8'($urandom);
      raddr    = 8'($urandom);
      if (it % 7 == 0) raddr[3:0] = waddr;
      #1;
      for (int k = 0; k < NR; k++) begin
        n_checks++;
        if (dout_b[k*W +: W] !== exp_rd(raddr[k*D +: D], 1'b1)) begin
          n_fail++; $display("FAIL rand_b it %0d port %0d addr %0d: got %h want %h",
                             it, k, raddr[k*D +: D], dout_b[k*W +: W], exp_rd(raddr[k*D +: D], 1'b1));
        end
        n_checks++;
        if (dout_n[k*W +: W] !== exp_rd(raddr[k*D +: D], 1'b0)) begin
          n_fail++; $display("FAIL rand_n it %0d port %0d addr %0d: got %h want %h",
                             it, k, raddr[k*D +: D], dout_n[k*W +: W], exp_rd(raddr[k*D +: D], 1'b0));
        end
      end
      n_checks++;
      if (t0_b !== exp_rd(4'd13, 1'b1) || t1_b !== exp_rd(4'd14, 1'b1)) begin
        n_fail++; $display("FAIL rand_taps it %0d: got %h %h want %h %h",
                           it, t0_b, t1_b, exp_rd(4'd13, 1'b1), exp_rd(4'd14, 1'b1));
      end
      @(posedge clk); commit(); #1;
      n_checks++;
      if (dirty_b !== mdirty || dirty_n !== mdirty) begin
        n_fail++; $display("FAIL rand_dirty it %0d: got %h %h want %h", it, dirty_b, dirty_n, mdirty);
      end
    end
    write_en = 1'b0;
  endtask

  task automatic fill_regs(input logic [W-1:0] salt);
    for (int i = 0; i < 15; i++) begin
      write_en = 1'b1; waddr = 4'(i); data_in = 8'(i + 1) | 8'h80 ^ salt;
      @(posedge clk); commit(); #1;
    end
    write_en = 1'b0;
  endtask

  task automatic test_clear();
    int j, busy_cnt, done_cnt, done_at;
    bit finished;
    logic [D-1:0] a;
    logic [W-1:0] e;
    fill_regs(8'h00);
    write_en = 1'b1; waddr = 4'd4; data_in = 8'h77; clear_req = 1'b1;
    @(posedge clk); commit(); #1;
    clear_req = 1'b0;
    for (int i = 0; i < NREG; i++) snap[i] = mreg[i];
    j = 0; busy_cnt = 0; done_cnt = 0; done_at = -1; finished = 1'b0;
    while (j < 40 && !finished) begin
      write_en = 1'b1;
      waddr    = 4'($urandom);
      data_in  = 8'($urandom);
      raddr    = {4'($urandom), 4'd4};
      #1;
      if (!busy_b) begin
        finished = 1'b1;
      end else begin
        busy_cnt++;
        if (done_b) begin
          done_cnt++;
          done_at = j;
        end
        for (int k = 0; k < NR; k++) begin
          a = raddr[k*D +: D];
          e = (a == ZA || int'(a) < j) ? 8'h00 : snap[a];
          n_checks++;
          if (dout_b[k*W +: W] !== e || dout_n[k*W +: W] !== e) begin
            n_fail++; $display("FAIL clear_read cyc %0d port %0d addr %0d: got %h %h want %h",
                               j, k, a, dout_b[k*W +: W], dout_n[k*W +: W], e);
          end
        end
        @(posedge clk); #1;
        j++;
      end
    end
    write_en = 1'b0;
    model_zero();
    n_checks++;
    if (!finished) begin
      n_fail++; $display("FAIL clear_timeout: busy still %b after %0d cycles, want 0", busy_b, j);
    end
    n_checks++;
    if (busy_cnt != 17) begin
      n_fail++; $display("FAIL clear_busy_len: got %0d want 17", busy_cnt);
    end
    n_checks++;
    if (done_cnt != 1 || done_at != 16) begin
      n_fail++; $display("FAIL clear_done_pulse: got %0d pulses at %0d want 1 at 16", done_cnt, done_at);
    end
    n_checks++;
    if (dirty_b !== mdirty || dirty_n !== mdirty) begin
      n_fail++; $display("FAIL clear_dirty: got %h %h want %h", dirty_b, dirty_n, mdirty);
    end
    for (int i = 0; i < NREG; i++) begin
      raddr = {4'(i), 4'(i)};
      #1;
      n_checks++;
      if (dout_b !== {mreg[i], mreg[i]} || dout_n !== {mreg[i], mreg[i]}) begin
        n_fail++; $display("FAIL clear_contents reg %0d: got %h %h want %h%h", i, dout_b, dout_n, mreg[i], mreg[i]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int bad;
    fill_regs(8'h3C);
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_zero();
    n_checks++;
    if ({busy_b, busy_n, done_b, done_n} !== 4'b0000) begin
      n_fail++; $display("FAIL midclear_busy: got %b want 0000", {busy_b, busy_n, done_b, done_n});
    end
    n_checks++;
    if (dirty_b !== mdirty || dirty_n !== mdirty) begin
      n_fail++; $display("FAIL midclear_dirty: got %h %h want %h", dirty_b, dirty_n, mdirty);
    end
    for (int i = 0; i < NREG; i++) begin
      raddr = {4'(i), 4'(i)};
      #0.1;
      n_checks++;
      if (dout_b !== {mreg[i], mreg[i]} || dout_n !== {mreg[i], mreg[i]}) begin
        n_fail++; $display("FAIL midclear_contents reg %0d: got %h %h want 0000", i, dout_b, dout_n);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (busy_b || done_b || busy_n || done_n) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL midclear_no_done: got %0d busy/done cycles want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_taps();
    test_random();
    test_clear();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
